// File: rtl/inv_subbytes_sequential.sv
// Iterative AES InvSubBytes: N_LANES composite-field GF((2^4)^2) inverse S-boxes swept over the state.
// Build option INV_SBOX_PIPE_REG_EN registers between map and inversion stages (+1 cycle latency).
`timescale 1ns/1ps

module inv_sbox_lane (
  input  logic [7:0] i_byte,
  output logic [7:0] o_map,
  input  logic [7:0] i_map,
  output logic [7:0] o_byte
);
  // GF(2^4) uses x^4+x+1; GF(2^8) is built as y^2+y+LAMBDA over it.
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] lin_map(input logic [7:0][7:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[i];
    return r;
  endfunction

  // Isomorphism columns are powers of the first composite-field root of the AES polynomial.
  function automatic logic [7:0][7:0] find_iso();
    logic [8:0][7:0] pw;
    logic [7:0][7:0] cols;
    logic            found;
    cols  = '0;
    found = 1'b0;
    for (int b = 2; b < 256; b++) begin
      pw[0] = 8'h01;
      for (int i = 1; i < 9; i++) pw[i] = gf8_mul(pw[i-1], 8'(b));
      if (!found && (pw[8] ^ pw[4] ^ pw[3] ^ pw[1] ^ pw[0]) == 8'h00) begin
        found = 1'b1;
        cols  = pw[7:0];
      end
    end
    return cols;
  endfunction

  function automatic logic [7:0][7:0] invert(input logic [7:0][7:0] m);
    logic [7:0][7:0] r;
    logic [7:0]      v;
    r = '0;
    for (int y = 0; y < 256; y++) begin
      v = lin_map(m, 8'(y));
      for (int j = 0; j < 8; j++)
        if (v == (8'h01 << j)) r[j] = 8'(y);
    end
    return r;
  endfunction

  localparam logic [7:0][7:0] ISO     = find_iso();
  localparam logic [7:0][7:0] ISO_INV = invert(ISO);

  logic [7:0] aff, inv;
  logic [3:0] ah, al, d;

  assign aff    = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                  {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign o_map  = lin_map(ISO, aff);
  assign ah     = i_map[7:4];
  assign al     = i_map[3:0];
  assign d      = gf4_inv(gf4_mul(gf4_mul(ah, ah), LAMBDA) ^ gf4_mul(ah, al) ^ gf4_mul(al, al));
  assign inv    = {gf4_mul(ah, d), gf4_mul(ah ^ al, d)};
  assign o_byte = lin_map(ISO_INV, inv);
endmodule

module inv_subbytes_sequential #(
  parameter int NB_BYTE = 8,
  parameter int N_BYTES = 16,
  parameter int N_LANES = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [N_BYTES*NB_BYTE-1:0] i_state,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [N_BYTES*NB_BYTE-1:0] o_state
);
  localparam int N_GROUPS = N_BYTES / N_LANES;
  localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int CW       = $clog2(N_GROUPS + 1);
`ifdef INV_SBOX_PIPE_REG_EN
  localparam int LAST = N_GROUPS;
`else
  localparam int LAST = N_GROUPS - 1;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                                         state_q, state_d;
  logic [CW-1:0]                                  cnt_q, cnt_d;
  logic [N_GROUPS-1:0][N_LANES-1:0][NB_BYTE-1:0]  work_q, work_d;
  logic [N_LANES-1:0][7:0]                        lane_in, lane_map, lane_imap, lane_out;
  logic [GW-1:0]                                  rd_grp, wr_grp;
  logic                                           wr_en;

  assign rd_grp = (cnt_q < CW'(N_GROUPS)) ? GW'(cnt_q) : '0;

`ifdef INV_SBOX_PIPE_REG_EN
  // Write-back trails the read by one group while the pipe fills and drains.
  logic [N_LANES-1:0][7:0] pipe_q;
  always_ff @(posedge i_clock) begin
    if (i_reset) pipe_q <= '0;
    else         pipe_q <= lane_map;
  end
  assign lane_imap = pipe_q;
  assign wr_grp    = GW'(cnt_q - CW'(1));
  assign wr_en     = (cnt_q != '0);
`else
  assign lane_imap = lane_map;
  assign wr_grp    = rd_grp;
  assign wr_en     = 1'b1;
`endif

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign lane_in[l] = work_q[rd_grp][l];
    inv_sbox_lane u_lane (
      .i_byte (lane_in[l]),
      .o_map  (lane_map[l]),
      .i_map  (lane_imap[l]),
      .o_byte (lane_out[l])
    );
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: if (i_valid) begin
        work_d  = i_state;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (wr_en) work_d[wr_grp] = lane_out;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_state = work_q;
endmodule

// File: tb/tb_inv_subbytes_sequential.sv
// Bench for inv_subbytes_sequential: directed + random states against a FIPS-197 arithmetic model.
`timescale 1ns/1ps

module tb_inv_subbytes_sequential;
  localparam int N_GROUPS = 4;
`ifdef INV_SBOX_PIPE_REG_EN
  localparam int LAT = N_GROUPS + 1;
`else
  localparam int LAT = N_GROUPS;
`endif

  logic         clk = 1'b0;
  logic         rst, iv, ordy, ov, irdy;
  logic [127:0] ist, ost;

  always #5 clk = ~clk;

  inv_subbytes_sequential dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_valid (iv),
    .o_ready (ordy),
    .i_state (ist),
    .o_valid (ov),
    .i_ready (irdy),
    .o_state (ost)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sbox [256];
  logic [7:0] isb  [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = isb[s[8*j +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic run(input logic [127:0] st, input string tag, output logic [127:0] res);
    int n;
    chk({tag, "_rdy"}, 128'(ordy), 128'(1));
    iv  = 1'b1;
    ist = st;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    n  = 0;
    while (ov !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    res  = ost;
    irdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    irdy = 1'b0;
    chk({tag, "_drop"}, 128'({ov, ordy}), 128'(2'b01));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st, r, orig;
    logic [7:0]   b;
    logic [127:0] q [3];
    logic [127:0] rs [3];
    int           tv [3];
    int           perm [256];
    int           n, k, tmp, idx, nres;
    logic         stable, seen, acc;

    // Golden tables from field arithmetic: brute-force inverse, forward affine, then invert the table.
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      isb[sbox[x]] = 8'(x);
    end

    rst = 1'b1; iv = 1'b0; irdy = 1'b0; ist = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(ov), 128'(0));
    chk("rst_ready", 128'(ordy), 128'(1));
    chk("rst_state", ost, 128'(0));
    rst = 1'b0;

    run({16{8'h63}}, "k63", r); chk("k63", r, {16{8'h00}});
    run({16{8'h00}}, "k00", r); chk("k00", r, {16{8'h52}});
    run({16{8'hFF}}, "kFF", r); chk("kFF", r, {16{8'h7D}});
    run({16{8'hED}}, "kED", r); chk("kED", r, {16{8'h53}});

    for (int j = 0; j < 16; j++) st[8*j +: 8] = 8'(j);
    run(st, "pos", r);
    for (int j = 0; j < 16; j++)
      chk($sformatf("pos%0d", j), 128'(r[8*j +: 8]), 128'(isb[j]));

    // Round trip over a shuffled permutation of all 256 byte values.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      k = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[k]; perm[k] = tmp;
    end
    for (int s = 0; s < 16; s++) begin
      for (int j = 0; j < 16; j++) begin
        orig[8*j +: 8] = 8'(perm[16*s + j]);
        st[8*j +: 8]   = sbox[orig[8*j +: 8]];
      end
      run(st, $sformatf("rt%0d", s), r);
      chk($sformatf("rt%0d", s), r, orig);
    end

    for (int i = 0; i < 6; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      run(st, $sformatf("rnd%0d", i), r);
      chk($sformatf("rnd%0d", i), r, model(st));
    end

    // Backpressure: i_valid toggles while busy, then i_ready held low in DONE.
    st = {$urandom, $urandom, $urandom, $urandom};
    iv = 1'b1; ist = st;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (ov !== 1'b1 && n < 20) begin
      iv = ~iv;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("bp_lat", 128'(n), 128'(LAT));
    r = ost;
    chk("bp_res", r, model(st));
    iv = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (ov !== 1'b1 || ost !== r) stable = 1'b0;
    end
    chk("bp_hold", 128'(stable), 128'(1));
    iv = 1'b0; irdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    irdy = 1'b0;
    chk("bp_drop", 128'({ov, ordy}), 128'(2'b01));

    // Reset while cnt==2: the partial result must be discarded.
    st = {$urandom, $urandom, $urandom, $urandom};
    iv = 1'b1; ist = st;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 128'(ov), 128'(0));
    chk("mr_ready", 128'(ordy), 128'(1));
    chk("mr_state", ost, 128'(0));
    seen = 1'b0; irdy = 1'b1;
    repeat (LAT + 3) begin
      @(posedge clk);
      @(negedge clk);
      if (ov === 1'b1) seen = 1'b1;
    end
    irdy = 1'b0;
    chk("mr_ghost", 128'(seen), 128'(0));
    st = {$urandom, $urandom, $urandom, $urandom};
    run(st, "mr_next", r);
    chk("mr_next", r, model(st));

    // Back-to-back with i_valid and i_ready held high.
    for (int i = 0; i < 3; i++) begin
      q[i] = {$urandom, $urandom, $urandom, $urandom};
      rs[i] = '0;
      tv[i] = 0;
    end
    idx = 0; nres = 0;
    iv = 1'b1; ist = q[0]; irdy = 1'b1;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      if (ov === 1'b1) begin
        rs[nres] = ost;
        tv[nres] = c;
        nres++;
      end
      acc = ordy && iv;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) ist = q[idx];
        else         iv = 1'b0;
      end
    end
    iv = 1'b0; irdy = 1'b0;
    chk("b2b_count", 128'(nres), 128'(3));
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_res%0d", i), rs[i], model(q[i]));
    chk("b2b_gap01", 128'(tv[1] - tv[0]), 128'(LAT + 2));
    chk("b2b_gap12", 128'(tv[2] - tv[1]), 128'(LAT + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
